split_sat_collector: RTL and testbench

- Downstream stage of the per-constraint split evaluators.
- Each accepted beat carries one candidate assignment's vector of split outputs (one bit per split_N x).
- Candidate is satisfying iff all split bits are 1.
- Block accumulates per-batch statistics and emits one registered summary per batch to the solver control/BDD pruning logic through a valid/ready handshake.

---
 rtl/split_sat_collector_if.sv | 28 ++
 rtl/split_sat_collector.sv | 110 +++++++++++
 tb/tb_split_sat_collector.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/split_sat_collector_if.sv
// Handshake bundle between the split evaluators, the collector and the solver control.
// The candidate-beat stream and the batch-summary stream share one interface.
interface split_sat_collector_if #(
  parameter int NUM_SPLITS = 8,
  parameter int CNT_W      = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [NUM_SPLITS-1:0] in_split;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [CNT_W-1:0]      out_total;
  logic [CNT_W-1:0]      out_sat;
  logic [NUM_SPLITS-1:0] out_fail_mask;
  logic [CNT_W-1:0]      out_first_sat;
  logic                  out_any_sat;

  modport master (
    output in_valid, in_split, in_last, out_ready,
    input  in_ready, out_valid, out_total, out_sat, out_fail_mask, out_first_sat, out_any_sat
  );

  modport slave (
    input  in_valid, in_split, in_last, out_ready,
    output in_ready, out_valid, out_total, out_sat, out_fail_mask, out_first_sat, out_any_sat
  );
endinterface

// File: rtl/split_sat_collector.sv
// Collects per-candidate split outputs into per-batch statistics and emits one
// registered summary per batch over a valid/ready handshake.
module split_sat_collector #(
  parameter int NUM_SPLITS = 8,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  split_sat_collector_if.slave   bus
);
  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]            state_reg, state_next;
  logic                  ready_reg;
  logic                  valid_reg;

  logic [CNT_W-1:0]      total_acc_reg;
  logic [CNT_W-1:0]      sat_acc_reg;
  logic [CNT_W-1:0]      first_acc_reg;
  logic                  first_seen_reg;
  logic [NUM_SPLITS-1:0] mask_acc_reg;

  logic [CNT_W-1:0]      total_reg;
  logic [CNT_W-1:0]      sat_reg;
  logic [CNT_W-1:0]      first_reg;
  logic [NUM_SPLITS-1:0] mask_reg;
  logic                  any_reg;

  logic                  accept;
  logic                  beat_sat;
  logic                  take_first;
  logic [CNT_W-1:0]      total_next;
  logic [CNT_W-1:0]      sat_next;
  logic [CNT_W-1:0]      first_next;
  logic [NUM_SPLITS-1:0] mask_next;

  // Ready is registered so it never depends combinationally on in_valid.
  assign accept     = bus.in_valid && ready_reg;
  assign beat_sat   = &bus.in_split;
  assign take_first = beat_sat && !first_seen_reg;

  // Accumulator values including the current beat's contribution.
  always_comb begin
    total_next = (&total_acc_reg) ? total_acc_reg : total_acc_reg + CNT_W'(1);
    sat_next   = (beat_sat && !(&sat_acc_reg)) ? sat_acc_reg + CNT_W'(1) : sat_acc_reg;
    first_next = take_first ? total_acc_reg : first_acc_reg;
    mask_next  = mask_acc_reg | ~bus.in_split;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACCUM:   if (accept && bus.in_last) state_next = HOLD;
      HOLD:    if (valid_reg && bus.out_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ACCUM;
      ready_reg      <= 1'b0;
      valid_reg      <= 1'b0;
      total_acc_reg  <= '0;
      sat_acc_reg    <= '0;
      first_acc_reg  <= '0;
      first_seen_reg <= 1'b0;
      mask_acc_reg   <= '0;
      total_reg      <= '0;
      sat_reg        <= '0;
      first_reg      <= '0;
      mask_reg       <= '0;
      any_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= (state_next == ACCUM);
      valid_reg <= (state_next == HOLD);
      if (accept) begin
        if (bus.in_last) begin
          // Close the batch: publish final values and start the next batch clean.
          total_reg      <= total_next;
          sat_reg        <= sat_next;
          first_reg      <= first_next;
          mask_reg       <= mask_next;
          any_reg        <= (sat_next != '0);
          total_acc_reg  <= '0;
          sat_acc_reg    <= '0;
          first_acc_reg  <= '0;
          first_seen_reg <= 1'b0;
          mask_acc_reg   <= '0;
        end else begin
          total_acc_reg  <= total_next;
          sat_acc_reg    <= sat_next;
          first_acc_reg  <= first_next;
          first_seen_reg <= first_seen_reg | beat_sat;
          mask_acc_reg   <= mask_next;
        end
      end
    end
  end

  assign bus.in_ready      = ready_reg;
  assign bus.out_valid     = valid_reg;
  assign bus.out_total     = total_reg;
  assign bus.out_sat       = sat_reg;
  assign bus.out_first_sat = first_reg;
  assign bus.out_fail_mask = mask_reg;
  assign bus.out_any_sat   = any_reg;
endmodule

// File: tb/tb_split_sat_collector.sv
// Scoreboard bench: a 16-bit and a 4-bit counter build see identical stimulus;
// expected summaries are queued per build and checked by monitors at each handshake.
module tb_split_sat_collector;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    int total;
    int sat;
    int mask;
    int first;
    int any;
  } exp_t;

  exp_t q16[$];
  exp_t q4[$];

  always #5 clk = ~clk;

  split_sat_collector_if #(.NUM_SPLITS(8), .CNT_W(16)) bus  ();
  split_sat_collector_if #(.NUM_SPLITS(8), .CNT_W(4))  bus4 ();

  assign bus4.in_valid  = bus.in_valid;
  assign bus4.in_split  = bus.in_split;
  assign bus4.in_last   = bus.in_last;
  assign bus4.out_ready = bus.out_ready;

  split_sat_collector #(.NUM_SPLITS(8), .CNT_W(16)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  split_sat_collector #(.NUM_SPLITS(8), .CNT_W(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: one pop per accepted summary.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q16.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL dut16_unexpected_summary: got total=%0d expected no summary", bus.out_total);
      end else begin
        exp_t e;
        e = q16.pop_front();
        check("dut16_total", 32'(bus.out_total), e.total);
        check("dut16_sat",   32'(bus.out_sat),   e.sat);
        check("dut16_mask",  32'(bus.out_fail_mask), e.mask);
        check("dut16_any",   32'(bus.out_any_sat), e.any);
        if (e.any != 0) check("dut16_first", 32'(bus.out_first_sat), e.first);
        $display("[TB] dut16 summary total=%0d sat=%0d mask=%02h first=%0d any=%0d",
                 bus.out_total, bus.out_sat, bus.out_fail_mask, bus.out_first_sat, bus.out_any_sat);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus4.out_valid && bus4.out_ready) begin
      if (q4.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL dut4_unexpected_summary: got total=%0d expected no summary", bus4.out_total);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("dut4_total", 32'(bus4.out_total), e.total);
        check("dut4_sat",   32'(bus4.out_sat),   e.sat);
        check("dut4_mask",  32'(bus4.out_fail_mask), e.mask);
        check("dut4_any",   32'(bus4.out_any_sat), e.any);
        if (e.any != 0) check("dut4_first", 32'(bus4.out_first_sat), e.first);
        $display("[TB] dut4 summary total=%0d sat=%0d mask=%02h first=%0d any=%0d",
                 bus4.out_total, bus4.out_sat, bus4.out_fail_mask, bus4.out_first_sat, bus4.out_any_sat);
      end
    end
  end

  task automatic expect_both(input int total, input int sat, input int mask,
                             input int first, input int total4, input int sat4);
    exp_t e;
    e = '{total: total, sat: sat, mask: mask, first: first, any: (sat != 0) ? 1 : 0};
    q16.push_back(e);
    e.total = total4;
    e.sat   = sat4;
    q4.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send_beat(input logic [7:0] s, input logic last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_split = s;
    bus.in_last  = last;
    while (!(bus.in_ready && bus4.in_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      tests++;
      fails++;
      $display("[TB] FAIL in_ready_timeout: got in_ready=0 expected 1 within 20 cycles");
    end
    @(negedge clk);
  endtask

  task automatic finish_batch();
    int n = 0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("latency_out_valid16", 32'(bus.out_valid), 1);
    check("latency_out_valid4",  32'(bus4.out_valid), 1);
    while ((bus.out_valid || bus4.out_valid) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      tests++;
      fails++;
      $display("[TB] FAIL out_valid_drop_timeout: got out_valid=1 expected 0 within 20 cycles");
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_split  = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_total",     32'(bus.out_total), 0);
    check("rst_sat",       32'(bus.out_sat), 0);
    check("rst_mask",      32'(bus.out_fail_mask), 0);
    check("rst_first",     32'(bus.out_first_sat), 0);
    check("rst_any",       32'(bus.out_any_sat), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Mixed batch: two satisfying, bits 0 and 7 fail once each.
    expect_both(4, 2, 'h81, 0, 4, 2);
    send_beat(8'hFF, 1'b0);
    send_beat(8'h7F, 1'b0);
    send_beat(8'hFF, 1'b0);
    send_beat(8'hFE, 1'b1);
    finish_batch();

    // All-zero batch: nothing satisfies, every bit fails.
    expect_both(3, 0, 'hFF, 0, 3, 0);
    send_beat(8'h00, 1'b0);
    send_beat(8'h00, 1'b0);
    send_beat(8'h00, 1'b1);
    finish_batch();

    // Back-pressure: summary must hold for 5 cycles and ignore input pulses.
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    expect_both(2, 1, 'h02, 0, 2, 1);
    send_beat(8'hFF, 1'b0);
    send_beat(8'hFD, 1'b1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold_out_valid", 32'(bus.out_valid), 1);
      check("hold_in_ready",  32'(bus.in_ready), 0);
      check("hold_total",     32'(bus.out_total), 2);
      check("hold_sat",       32'(bus.out_sat), 1);
      check("hold_mask",      32'(bus.out_fail_mask), 'h02);
      check("hold_in_ready4", 32'(bus4.in_ready), 0);
      bus.in_valid = (i == 1 || i == 3);
      bus.in_split = 8'h00;
      bus.in_last  = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_hs_out_valid", 32'(bus.out_valid), 0);
    check("post_hs_in_ready",  32'(bus.in_ready), 1);

    // Single-beat batch right after the held one: accumulators must be clean.
    expect_both(1, 1, 'h00, 0, 1, 1);
    send_beat(8'hFF, 1'b1);
    finish_batch();

    // 20 satisfying beats: the 4-bit build saturates at 15.
    expect_both(20, 20, 'h00, 0, 15, 15);
    for (int i = 0; i < 20; i++) send_beat(8'hFF, (i == 19));
    finish_batch();

    // Reset mid-batch: the partial batch must never produce a summary.
    send_beat(8'h00, 1'b0);
    send_beat(8'hFF, 1'b0);
    send_beat(8'hFF, 1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready",   32'(bus.in_ready), 0);
    check("midrst_out_valid",  32'(bus.out_valid), 0);
    check("midrst_total",      32'(bus.out_total), 0);
    check("midrst_sat4",       32'(bus4.out_sat), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_both(2, 1, 'h80, 1, 2, 1);
    send_beat(8'h7F, 1'b0);
    send_beat(8'hFF, 1'b1);
    finish_batch();

    repeat (5) @(negedge clk);
    check("q16_drained", 32'(q16.size()), 0);
    check("q4_drained",  32'(q4.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
